// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : shared state encoding and parameter defaults for product_accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int GUARD_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/product_extend.sv
// ============================================================================
// product_extend : widens a 2n-bit product to W bits, signed or unsigned
// Revision: 1.0
// ============================================================================
`default_nettype none

module product_extend
  import acc_pkg::*;
#(
  parameter int n     = N_DEFAULT,
  parameter int guard = GUARD_DEFAULT
) (
  input  logic [2*n-1:0]       prod,
  input  logic                 is_signed,
  output logic [2*n+guard-1:0] ext
);

  logic ext_bit;

  assign ext_bit = is_signed & prod[2*n-1];
  assign ext     = {{guard{ext_bit}}, prod};

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator : sums a packet of multiplier products, emits sum/count/ovf
// Revision: 1.0
// ============================================================================
`default_nettype none

module product_accumulator
  import acc_pkg::*;
#(
  parameter int n     = N_DEFAULT,
  parameter int guard = GUARD_DEFAULT,
  parameter int cnt_w = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_vld,
  output logic                   up_rdy,
  input  logic [2*n-1:0]         up_prod,
  input  logic                   up_signed,
  input  logic                   up_last,
  output logic                   down_vld,
  input  logic                   down_rdy,
  output logic [2*n+guard-1:0]   down_sum,
  output logic [cnt_w-1:0]       down_cnt,
  output logic                   down_ovf
);

  localparam int W = 2*n + guard;

  acc_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic             ext_mode;
  logic [W-1:0]     ext;
  logic [W:0]       sum_full;
  logic             ovf_hit;

  assign up_rdy   = (state_q != HOLD);
  assign down_vld = (state_q == HOLD);
  assign down_sum = acc_q;
  assign down_cnt = cnt_q;
  assign down_ovf = ovf_q;

  assign accept = up_vld & up_rdy;

  // The first beat defines the packet mode; later beats reuse the latched one.
  assign ext_mode = (state_q == IDLE) ? up_signed : mode_q;

  product_extend #(
    .n     (n),
    .guard (guard)
  ) u_extend (
    .prod      (up_prod),
    .is_signed (ext_mode),
    .ext       (ext)
  );

  assign sum_full = {1'b0, acc_q} + {1'b0, ext};
  assign ovf_hit  = mode_q ? ((acc_q[W-1] == ext[W-1]) && (sum_full[W-1] != acc_q[W-1]))
                           : sum_full[W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = up_signed;
          acc_d   = ext;
          cnt_d   = cnt_w'(1);
          ovf_d   = 1'b0;
          state_d = up_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = sum_full[W-1:0];
          cnt_d   = (cnt_q == {cnt_w{1'b1}}) ? cnt_q : cnt_q + cnt_w'(1);
          ovf_d   = ovf_q | ovf_hit;
          state_d = up_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (down_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// tb_product_accumulator : directed self-checking bench for product_accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        up_vld;
  logic        up_rdy;
  logic [15:0] up_prod;
  logic        up_signed;
  logic        up_last;
  logic        down_vld;
  logic        down_rdy;
  logic [19:0] down_sum;
  logic [7:0]  down_cnt;
  logic        down_ovf;

  int pass_cnt;
  int total_cnt;

  product_accumulator #(.n(8), .guard(4), .cnt_w(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld),
    .up_rdy    (up_rdy),
    .up_prod   (up_prod),
    .up_signed (up_signed),
    .up_last   (up_last),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_sum  (down_sum),
    .down_cnt  (down_cnt),
    .down_ovf  (down_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p, input logic s, input logic l);
    up_vld = 1'b1; up_prod = p; up_signed = s; up_last = l;
    step();
    up_vld = 1'b0; up_last = 1'b0;
  endtask

  task automatic drain();
    down_rdy = 1'b1;
    step();
    down_rdy = 1'b0;
  endtask

  logic [19:0] held_sum;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; up_vld = 1'b0; up_prod = '0; up_signed = 1'b0; up_last = 1'b0; down_rdy = 1'b0;
    #2;
    check("rst_down_vld", down_vld, 0);
    check("rst_up_rdy",   up_rdy,   1);
    check("rst_sum",      down_sum, 0);
    check("rst_cnt",      down_cnt, 0);
    check("rst_ovf",      down_ovf, 0);
    step();
    rst = 1'b0;
    step();

    // Unsigned 0xFE01 x3
    beat(16'hFE01, 1'b0, 1'b0);
    check("u3_vld_b1", down_vld, 0);
    beat(16'hFE01, 1'b0, 1'b0);
    check("u3_vld_b2", down_vld, 0);
    beat(16'hFE01, 1'b0, 1'b1);
    check("u3_vld", down_vld, 1);
    check("u3_sum", down_sum, 32'h2FA03);
    check("u3_cnt", down_cnt, 3);
    check("u3_ovf", down_ovf, 0);
    drain();
    check("u3_idle", down_vld, 0);

    // Signed -6 + 20; up_signed on beat 2 must be ignored
    beat(16'hFFFA, 1'b1, 1'b0);
    beat(16'h0014, 1'b0, 1'b1);
    check("s2_sum", down_sum, 32'h0000E);
    check("s2_cnt", down_cnt, 2);
    check("s2_ovf", down_ovf, 0);
    drain();

    // Single-beat signed 0x8000
    beat(16'h8000, 1'b1, 1'b1);
    check("s1_vld", down_vld, 1);
    check("s1_sum", down_sum, 32'hF8000);
    check("s1_cnt", down_cnt, 1);

    // Backpressure in HOLD with up_vld high
    held_sum = down_sum;
    up_vld = 1'b1; up_prod = 16'h0005; up_signed = 1'b0; up_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_up_rdy", up_rdy, 0);
      step();
      check("bp_vld", down_vld, 1);
      check("bp_sum", down_sum, held_sum);
      check("bp_cnt", down_cnt, 1);
    end
    down_rdy = 1'b1;
    step();
    down_rdy = 1'b0;
    check("bp_exit_vld", down_vld, 0);
    check("bp_exit_rdy", up_rdy, 1);
    check("bp_exit_sum", down_sum, 32'hF8000);
    step();
    up_vld = 1'b0; up_last = 1'b0;
    check("bp_next_vld", down_vld, 1);
    check("bp_next_sum", down_sum, 32'h00005);
    check("bp_next_cnt", down_cnt, 1);
    drain();

    // Unsigned 0xFFFF x17 wraps past 2^20
    for (int i = 0; i < 16; i++) beat(16'hFFFF, 1'b0, 1'b0);
    check("u17_ovf_pre", down_ovf, 0);
    check("u17_acc_pre", down_sum, 32'hFFFF0);
    beat(16'hFFFF, 1'b0, 1'b1);
    check("u17_sum", down_sum, 32'h0FFEF);
    check("u17_ovf", down_ovf, 1);
    check("u17_cnt", down_cnt, 17);
    drain();

    // Count saturation: 300 beats of 1
    for (int i = 0; i < 299; i++) beat(16'h0001, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b1);
    check("sat_cnt", down_cnt, 255);
    check("sat_sum", down_sum, 32'h0012C);
    check("sat_ovf", down_ovf, 0);
    drain();

    // Reset mid-packet discards it
    beat(16'h1234, 1'b1, 1'b0);
    beat(16'h1234, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mrst_vld", down_vld, 0);
    check("mrst_sum", down_sum, 0);
    check("mrst_cnt", down_cnt, 0);
    check("mrst_rdy", up_rdy, 1);
    step();
    rst = 1'b0;
    step();
    check("mrst_no_vld", down_vld, 0);
    beat(16'h0005, 1'b0, 1'b1);
    check("mrst_new_vld", down_vld, 1);
    check("mrst_new_sum", down_sum, 32'h00005);
    check("mrst_new_cnt", down_cnt, 1);
    check("mrst_new_ovf", down_ovf, 0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter n, default 8: operand width of the upstream multiplier; the product is 2n bits.
REQ-002 Parameter guard, default 4: accumulator guard bits; W = 2n + guard.
REQ-003 Parameter cnt_w, default 8: beat-counter width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 up_vld  in  1  upstream product valid.
REQ-007 up_rdy  out  1  block can accept a product this cycle.
REQ-008 up_prod  in  2n  product from the signed/unsigned multiplier stage.
REQ-009 up_signed  in  1  product is two's-complement (1) or unsigned (0).
REQ-010 up_last  in  1  final beat of the current packet.
REQ-011 down_vld  out  1  accumulated result valid.
REQ-012 down_rdy  in  1  downstream accepts the result.
REQ-013 down_sum  out  W  accumulated sum.
REQ-014 down_cnt  out  cnt_w  beats in the packet, saturating.
REQ-015 down_ovf  out  1  sticky overflow flag for the packet.

Function
REQ-016 A beat is accepted only on a cycle with up_vld and up_rdy both high.
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-018 up_rdy SHALL be combinationally high in IDLE and ACCUM, and low in HOLD.
REQ-019 The signed or unsigned mode of a packet SHALL be latched from up_signed on the first beat; up_signed on later beats is ignored.
REQ-020 Each product SHALL be extended to W bits using the latched mode: sign-extended if signed, zero-extended otherwise.
REQ-021 On a first beat (accepted in IDLE): acc is loaded with the extended product, cnt is set to 1, ovf is cleared.
REQ-022 On a later beat (accepted in ACCUM): acc becomes acc plus the extended product, modulo 2^W.
REQ-023 On a later beat, cnt increments and saturates at 2^cnt_w-1.
REQ-024 Unsigned overflow is a carry out of bit W-1; it sets ovf, which stays set for the rest of the packet.
REQ-025 Signed overflow occurs when both operands have equal sign and the result sign differs; it sets ovf, which stays set for the rest of the packet.
REQ-026 IDLE goes to ACCUM on an accepted beat with up_last low.
REQ-027 IDLE or ACCUM goes to HOLD on an accepted beat with up_last high; a single-beat packet goes IDLE to HOLD directly.
REQ-028 HOLD goes to IDLE on the cycle down_vld and down_rdy are both high.
REQ-029 down_vld SHALL be 1 exactly in HOLD, i.e. on the cycle after the last-beat accept (latency 1).
REQ-030 down_sum, down_cnt and down_ovf SHALL reflect acc, cnt and ovf and stay stable while down_vld is high.
REQ-031 No beat is accepted in the cycle HOLD exits; the next packet may start on the following cycle.
REQ-032 ACCUM with up_vld low SHALL hold all state indefinitely; there is no timeout.

Reset
REQ-033 rst high SHALL asynchronously force: state=IDLE, acc=0, cnt=0, ovf=0, mode=0.
REQ-034 Output values during reset SHALL be down_vld=0, up_rdy=1, down_sum=0, down_cnt=0, down_ovf=0.
REQ-035 Reset during ACCUM or HOLD SHALL discard the partial or pending packet, with no result emitted.

Structure
REQ-036 Shared package acc_pkg SHALL hold the state enum typedef (IDLE, ACCUM, HOLD) and the default values of n, guard and cnt_w.
REQ-037 One sub-module, product_extend, SHALL be combinational and map (2n-bit product, mode) to a W-bit extended value.
REQ-038 product_accumulator is placed directly downstream of signed_or_unsigned_mul.

Verification (n=8, guard=4, W=20)
REQ-039 Unsigned packet of 0xFE01 x3 -> down_sum=0x2FA03, down_cnt=3, down_ovf=0, down_vld on the cycle after beat 3.
REQ-040 Signed packet of 0xFFFA, then 0x0014 (last) -> down_sum=0x0000E, down_cnt=2, down_ovf=0.
REQ-041 Single-beat signed packet of 0x8000 (last) -> down_sum=0xF8000, down_cnt=1, IDLE to HOLD in one cycle.
REQ-042 Backpressure test, with down_rdy=0 for 5 cycles in HOLD and up_vld=1 throughout:
- down_vld stays 1 and outputs stay stable;
- up_rdy stays 0 and no beat is accepted;
- with down_rdy=1, FSM returns to IDLE; the next beat is accepted one cycle later.
REQ-043 Unsigned packet of 0xFFFF x17 -> down_sum=0x0FFEF (modulo 2^20), down_ovf=1, down_cnt=17.
REQ-044 Reset after 2 beats, then single-beat unsigned packet of 0x0005 -> down_sum=0x00005, down_cnt=1, no earlier down_vld.
